// File: rtl/trig_capture.sv
// Triggered sample capture: circular pre-trigger buffer, mask/value or external trigger,
// post-trigger sample count. Optional decimation enabled by defining TRIG_CAPTURE_DECIM_EN.
module trig_capture #(
    parameter int CAPTURE_WIDTH = 32,
    parameter int CAPTURE_SIZE  = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CAPTURE_WIDTH-1:0] capture_data,
    input  logic                     capture_data_valid,
    input  logic                     capture_arm,
    input  logic                     capture_stop,
    input  logic                     capture_reset,
    input  logic [CAPTURE_WIDTH-1:0] trig_mask,
    input  logic [CAPTURE_WIDTH-1:0] trig_value,
    input  logic                     trig_ext,
`ifdef TRIG_CAPTURE_DECIM_EN
    input  logic [15:0]              decim,
`endif
    input  logic [31:0]              post_count,
    input  logic [31:0]              capture_rd_addr,
    output logic [CAPTURE_WIDTH-1:0] capture_rd_data,
    output logic [31:0]              capture_size,
    output logic [31:0]              capture_amount,
    output logic [31:0]              capture_trig_index,
    output logic [1:0]               capture_state,
    output logic                     capture_done
);
    localparam int AW = $clog2(CAPTURE_SIZE);
    localparam logic [AW:0]   FULL     = (AW+1)'(CAPTURE_SIZE);
    localparam logic [AW-1:0] MAX_POST = AW'(CAPTURE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       trig_ptr;
    logic [AW-1:0]       post_left;
    logic [AW:0]         amount;
    logic                triggered;
    logic                active;
    logic                cand;
    logic                sample_ok;
    logic                do_write;
    logic                hit;
    logic [AW-1:0]       oldest;
    logic [AW-1:0]       rd_phys;
    logic [AW-1:0]       trig_rel;
    logic [CAPTURE_WIDTH-1:0] mem [CAPTURE_SIZE];

    assign active   = (state == ARMED) || (state == TRIGGERED);
    assign cand     = capture_data_valid && active && !capture_stop && !capture_reset;
    assign do_write = cand && sample_ok;
    assign hit      = do_write && (trig_ext || ((|trig_mask) &&
                      (((capture_data ^ trig_value) & trig_mask) == '0)));

`ifdef TRIG_CAPTURE_DECIM_EN
    logic [15:0] decim_lat;
    logic [15:0] decim_cnt;

    // Phase counter over valid samples; phase 0 is the one that gets stored.
    assign sample_ok = (decim_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset || capture_reset) begin
            decim_lat <= 16'd0;
            decim_cnt <= 16'd0;
        end else if (state == IDLE && capture_arm) begin
            decim_lat <= decim;
            decim_cnt <= 16'd0;
        end else if (cand) begin
            decim_cnt <= (decim_cnt == decim_lat) ? 16'd0 : decim_cnt + 16'd1;
        end
    end
`else
    assign sample_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (capture_arm) state_next = ARMED;
            ARMED: begin
                if (capture_stop)  state_next = DONE;
                else if (hit)      state_next = (post_left == '0) ? DONE : TRIGGERED;
            end
            TRIGGERED: begin
                if (capture_stop)                          state_next = DONE;
                else if (do_write && post_left == AW'(1))  state_next = DONE;
            end
            default: state_next = state;
        endcase
        if (capture_reset) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || capture_reset) begin
            wr_ptr    <= '0;
            amount    <= '0;
            trig_ptr  <= '0;
            triggered <= 1'b0;
            post_left <= '0;
        end else begin
            if (state == IDLE && capture_arm)
                post_left <= (post_count >= 32'(CAPTURE_SIZE - 1)) ? MAX_POST : post_count[AW-1:0];
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (amount != FULL) amount <= amount + (AW+1)'(1);
                if (state == TRIGGERED) post_left <= post_left - AW'(1);
            end
            if (state == ARMED && hit) begin
                trig_ptr  <= wr_ptr;
                triggered <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= capture_data;
    end

    // Once the buffer has wrapped, the write pointer marks the oldest sample.
    assign oldest  = (amount == FULL) ? wr_ptr : '0;
    assign rd_phys = oldest + capture_rd_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) capture_rd_data <= '0;
        else       capture_rd_data <= mem[rd_phys];
    end

    assign trig_rel           = trig_ptr - oldest;
    assign capture_trig_index = triggered ? {{(32-AW){1'b0}}, trig_rel} : 32'hFFFF_FFFF;
    assign capture_amount     = {{(31-AW){1'b0}}, amount};
    assign capture_size       = 32'(CAPTURE_SIZE);
    assign capture_state      = state;
    assign capture_done       = (state == DONE);

    logic unused_rd_addr;
    assign unused_rd_addr = ^capture_rd_addr[31:AW];
endmodule

// File: tb/tb_trig_capture.sv
// Self-checking bench for trig_capture (CAPTURE_SIZE=16): directed scenarios plus
// randomized rounds compared against a queue-based model of the captured sample stream.
module tb_trig_capture;
    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  capture_data = '0;
    logic          capture_data_valid = 1'b0;
    logic          capture_arm = 1'b0;
    logic          capture_stop = 1'b0;
    logic          capture_reset = 1'b0;
    logic [W-1:0]  trig_mask = '0;
    logic [W-1:0]  trig_value = '0;
    logic          trig_ext = 1'b0;
    logic [15:0]   decim = 16'd0;
    logic [31:0]   post_count = '0;
    logic [31:0]   capture_rd_addr = '0;
    logic [W-1:0]  capture_rd_data;
    logic [31:0]   capture_size;
    logic [31:0]   capture_amount;
    logic [31:0]   capture_trig_index;
    logic [1:0]    capture_state;
    logic          capture_done;

    int n_checks = 0;
    int n_errors = 0;

    trig_capture #(.CAPTURE_WIDTH(W), .CAPTURE_SIZE(N)) dut (
        .clk(clk), .reset(reset),
        .capture_data(capture_data), .capture_data_valid(capture_data_valid),
        .capture_arm(capture_arm), .capture_stop(capture_stop),
        .capture_reset(capture_reset), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_ext(trig_ext),
`ifdef TRIG_CAPTURE_DECIM_EN
        .decim(decim),
`endif
        .post_count(post_count), .capture_rd_addr(capture_rd_addr),
        .capture_rd_data(capture_rd_data), .capture_size(capture_size),
        .capture_amount(capture_amount), .capture_trig_index(capture_trig_index),
        .capture_state(capture_state), .capture_done(capture_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Reference model: every stored sample in order; the buffer is the last N of them.
    int          m_state = 0;
    logic [31:0] m_q[$];
    int          m_trig = -1;
    int          m_post = 0;
    int          m_decim = 0;
    int          m_cand = 0;

    function automatic int m_amount();
        return (m_q.size() > N) ? N : m_q.size();
    endfunction

    function automatic int m_start();
        return m_q.size() - m_amount();
    endfunction

    function automatic logic [31:0] m_trig_index();
        return (m_trig < 0) ? 32'hFFFF_FFFF : 32'(m_trig - m_start());
    endfunction

    task automatic model_edge();
        bit wr, hit;
        if (reset || capture_reset) begin
            m_state = 0; m_q.delete(); m_trig = -1;
            if (reset) m_post = 0;
            return;
        end
        case (m_state)
            0: if (capture_arm) begin
                m_state = 1;
                m_post  = (post_count > 32'(N - 1)) ? N - 1 : int'(post_count);
                m_cand  = 0;
`ifdef TRIG_CAPTURE_DECIM_EN
                m_decim = int'(decim);
`else
                m_decim = 0;
`endif
            end
            1, 2: if (capture_stop) m_state = 3;
                  else if (capture_data_valid) begin
                wr = (m_cand % (m_decim + 1)) == 0;
                m_cand++;
                if (wr) begin
                    m_q.push_back(capture_data);
                    if (m_state == 1) begin
                        hit = trig_ext || (trig_mask != 0 && ((capture_data ^ trig_value) & trig_mask) == 0);
                        if (hit) begin
                            m_trig  = m_q.size() - 1;
                            m_state = (m_post == 0) ? 3 : 2;
                        end
                    end else begin
                        m_post--;
                        if (m_post == 0) m_state = 3;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_state"}, 32'(capture_state), 32'(m_state));
        check({tag, "_amount"}, capture_amount, 32'(m_amount()));
        check({tag, "_trig"}, capture_trig_index, m_trig_index());
        check({tag, "_done"}, 32'(capture_done), 32'(m_state == 3));
    endtask

    task automatic idle_inputs();
        capture_data_valid = 1'b0; capture_arm = 1'b0; capture_stop = 1'b0;
        capture_reset = 1'b0; trig_ext = 1'b0;
    endtask

    task automatic soft_clear();
        idle_inputs();
        capture_reset = 1'b1; tick(); capture_reset = 1'b0;
        check_status("clr");
    endtask

    task automatic arm(input logic [31:0] post, input logic [31:0] mask, input logic [31:0] value);
        post_count = post; trig_mask = mask; trig_value = value;
        capture_arm = 1'b1; tick(); capture_arm = 1'b0;
        check_status("arm");
    endtask

    task automatic feed(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            capture_data = 32'(first + i); capture_data_valid = 1'b1;
            tick(); check_status("feed");
        end
        capture_data_valid = 1'b0;
    endtask

    task automatic read_at(input int idx, output logic [31:0] val);
        capture_rd_addr = 32'(idx); tick(); val = capture_rd_data;
    endtask

    task automatic read_all_model(input string tag);
        logic [31:0] v;
        for (int i = 0; i < m_amount(); i++) begin
            read_at(i, v);
            check($sformatf("%s_rd%0d", tag, i), v, m_q[m_start() + i]);
        end
    endtask

    initial begin
        logic [31:0] v;
        tick(); tick();
        check("rst_state", 32'(capture_state), 32'd0);
        check("rst_amount", capture_amount, 32'd0);
        check("rst_trig", capture_trig_index, 32'hFFFF_FFFF);
        check("rst_done", 32'(capture_done), 32'd0);
        check("rst_rd_data", capture_rd_data, 32'd0);
        check("size", capture_size, 32'd16);
        reset = 1'b0;

        // Trigger at 20, three post samples.
        soft_clear(); arm(32'd3, 32'hFFFF_FFFF, 32'd20); feed(0, 30);
        check("t1_state", 32'(capture_state), 32'd3);
        check("t1_amount", capture_amount, 32'd16);
        check("t1_trig", capture_trig_index, 32'd12);
        for (int i = 0; i < 16; i++) begin
            read_at(i, v); check($sformatf("t1_rd%0d", i), v, 32'(8 + i));
        end

        // Arm is ignored while DONE.
        capture_arm = 1'b1; tick(); capture_arm = 1'b0; check_status("done_arm");
        check("t1b_state", 32'(capture_state), 32'd3);

        // post_count clamps to 15.
        soft_clear(); arm(32'd100, 32'hFFFF_FFFF, 32'd20); feed(0, 41);
        check("t2_state", 32'(capture_state), 32'd3);
        check("t2_amount", capture_amount, 32'd16);
        check("t2_trig", capture_trig_index, 32'd0);
        read_at(0, v); check("t2_rd0", v, 32'd20);
        read_at(15, v); check("t2_rd15", v, 32'd35);

        // post_count 0 ends on the trigger sample itself.
        soft_clear(); arm(32'd0, 32'hFFFF_FFFF, 32'd5); feed(0, 10);
        check("t3_amount", capture_amount, 32'd6);
        check("t3_trig", capture_trig_index, 32'd5);
        read_all_model("t3");

        // Forced stop without trigger.
        soft_clear(); arm(32'd3, 32'h0, 32'd0); feed(100, 5);
        capture_stop = 1'b1; tick(); capture_stop = 1'b0; check_status("stop");
        check("t4_state", 32'(capture_state), 32'd3);
        check("t4_amount", capture_amount, 32'd5);
        check("t4_trig", capture_trig_index, 32'hFFFF_FFFF);
        read_at(0, v); check("t4_rd0", v, 32'd100);

        // capture_reset wins over a simultaneous hit.
        soft_clear(); arm(32'd3, 32'h0, 32'd0);
        capture_data = 32'd7; capture_data_valid = 1'b1; trig_ext = 1'b1; capture_reset = 1'b1;
        tick(); idle_inputs(); check_status("crst");
        check("t5_state", 32'(capture_state), 32'd0);
        check("t5_amount", capture_amount, 32'd0);

        // Mask zero: never triggers, buffer wraps.
        soft_clear(); arm(32'd3, 32'h0, 32'd0); feed(200, 40);
        check("t6_state", 32'(capture_state), 32'd1);
        check("t6_amount", capture_amount, 32'd16);
        capture_stop = 1'b1; tick(); capture_stop = 1'b0; check_status("t6stop");
        read_all_model("t6");

`ifdef TRIG_CAPTURE_DECIM_EN
        soft_clear(); decim = 16'd1; arm(32'd3, 32'h0, 32'd0); feed(0, 10);
        capture_stop = 1'b1; tick(); capture_stop = 1'b0; check_status("dstop");
        check("t7_amount", capture_amount, 32'd5);
        for (int i = 0; i < 5; i++) begin
            read_at(i, v); check($sformatf("t7_rd%0d", i), v, 32'(2 * i));
        end
        decim = 16'd0;
`endif

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            logic [31:0] mask;
            soft_clear();
            case ($urandom_range(0, 3))
                0: mask = 32'h0;
                1: mask = 32'h0000_000F;
                2: mask = 32'hFFFF_FFFF;
                default: mask = 32'h0000_0003;
            endcase
`ifdef TRIG_CAPTURE_DECIM_EN
            decim = 16'($urandom_range(0, 2));
`endif
            arm(32'($urandom_range(0, 20)), mask, 32'($urandom_range(0, 15)));
            for (int c = 0; c < 60; c++) begin
                capture_data       = 32'($urandom_range(0, 255));
                capture_data_valid = ($urandom_range(0, 3) != 0);
                trig_ext           = ($urandom_range(0, 40) == 0);
                capture_stop       = ($urandom_range(0, 80) == 0);
                capture_arm        = ($urandom_range(0, 20) == 0);
                tick(); check_status("rnd");
            end
            idle_inputs();
            capture_stop = 1'b1; tick(); capture_stop = 1'b0; check_status("rnd_end");
            read_all_model("rnd");
        end

        // Hard reset in the middle of a capture.
        soft_clear(); arm(32'd5, 32'h0, 32'd0); feed(50, 7);
        reset = 1'b1; tick(); check_status("hrst");
        check("hrst_rd_data", capture_rd_data, 32'd0);
        check("hrst_state", 32'(capture_state), 32'd0);
        reset = 1'b0; tick(); check_status("post_hrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/trig_capture.md
TRIG_CAPTURE -- requirements
Module: trig_capture

Interface
REQ-001 SHALL have parameter CAPTURE_WIDTH, default 32: sample width in bits.
REQ-002 SHALL have parameter CAPTURE_SIZE, default 256: buffer depth in samples; power of two, 4 or more; AW = $clog2(CAPTURE_SIZE).
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- capture_data  in  CAPTURE_WIDTH  sample.
- capture_data_valid  in  1  sample qualifier.
- capture_arm  in  1  pulse; IDLE->ARMED.
- capture_stop  in  1  forced end of capture.
- capture_reset  in  1  soft clear back to IDLE.
- trig_mask  in  CAPTURE_WIDTH  compare mask; all-zero disables the data compare.
- trig_value  in  CAPTURE_WIDTH  compare value.
- trig_ext  in  1  external trigger.
- post_count  in  32  samples captured after the trigger sample; latched at arm.
- capture_rd_addr  in  32  logical read index; 0 = oldest sample.
- capture_rd_data  out  CAPTURE_WIDTH  read data.
- capture_size  out  32  constant CAPTURE_SIZE.
- capture_amount  out  32  valid samples held.
- capture_trig_index  out  32  logical index of the trigger sample.
- capture_state  out  2  current FSM state.
- capture_done  out  1  high while in DONE.

Function
REQ-004 SHALL implement FSM states IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
REQ-005 SHALL define write as: capture_data_valid high in ARMED or TRIGGERED with no capture_stop or capture_reset that cycle. A write stores to RAM[wr_ptr], then wr_ptr = (wr_ptr+1) mod CAPTURE_SIZE and amount = min(amount+1, CAPTURE_SIZE).
REQ-006 SHALL define hit as: a write cycle where (trig_ext) OR (trig_mask!=0 AND ((capture_data^trig_value)&trig_mask)==0).
REQ-007 IDLE: capture_arm SHALL latch post_left = min(post_count, CAPTURE_SIZE-1) and go to ARMED. No write SHALL occur in the arm cycle.
REQ-008 ARMED: on a hit, the sample SHALL be written, trig_ptr = wr_ptr latched, and the FSM SHALL go to TRIGGERED, or directly to DONE if post_left==0. Pre-trigger data SHALL wrap circularly.
REQ-009 TRIGGERED: each write SHALL decrement post_left; the write that takes post_left to 0 SHALL move the FSM to DONE at the next edge. Further hits SHALL be ignored.
REQ-010 DONE: no writes. State SHALL hold until capture_reset; capture_arm SHALL be ignored.
REQ-011 capture_stop in ARMED or TRIGGERED SHALL go to DONE with no write. If no trigger occurred, capture_trig_index SHALL read 32'hFFFFFFFF.
REQ-012 capture_reset SHALL take priority over all inputs in any state. It SHALL cause IDLE, wr_ptr=0, amount=0, trig_ptr cleared, and capture_trig_index=32'hFFFFFFFF at the next edge.
REQ-013 SHALL compute oldest = (amount==CAPTURE_SIZE) ? wr_ptr : 0. Read physical address = (oldest + capture_rd_addr[AW-1:0]) mod CAPTURE_SIZE.
REQ-014 capture_rd_data SHALL be registered, valid 1 cycle after capture_rd_addr. Reads of index >= amount return undefined data.
REQ-015 capture_trig_index SHALL equal (trig_ptr - oldest) mod CAPTURE_SIZE once triggered, updated combinationally from registers.
REQ-016 SHALL use AW-bit pointer arithmetic wrapping modulo CAPTURE_SIZE. amount SHALL saturate at CAPTURE_SIZE.
REQ-017 SHALL provide a single-write/single-read port RAM, inferred, with no reset on contents.

Reset
REQ-018 reset SHALL force capture_state=0, capture_amount=0, capture_trig_index=32'hFFFFFFFF, capture_done=0, capture_rd_data=0, wr_ptr=0 and post_left=0, and SHALL override capture_reset.
REQ-019 reset mid-capture SHALL abandon the capture. RAM contents are undefined afterwards.

Configuration
REQ-020 With TRIG_CAPTURE_DECIM_EN defined, SHALL add input decim (16 bits, latched at arm). Only every (decim+1)-th valid sample, starting with the first, SHALL count as a write. Hits SHALL be evaluated on written samples only.
REQ-021 Without TRIG_CAPTURE_DECIM_EN, the decim port SHALL be absent and every valid sample SHALL be a write candidate.

Verification (CAPTURE_SIZE=16, CAPTURE_WIDTH=32)
REQ-022 Arm, post_count=3, mask=FFFFFFFF, value=20, data 0..29 all valid -> DONE after sample 23; amount=16; reads 0..15 return 8..23; trig_index=12.
REQ-023 Same stimulus, post_count=100 -> clamped to 15; DONE after sample 35 (data 0..40); trig_index=0.
REQ-024 Arm, 5 samples, capture_stop -> DONE; amount=5; trig_index=FFFFFFFF; read 0 returns the first sample.
REQ-025 Hit with trig_ext=1 in the same cycle as capture_reset -> IDLE; no write; amount=0.
REQ-026 mask=0, trig_ext=0, 40 samples -> stays ARMED; amount=16.
REQ-027 With TRIG_CAPTURE_DECIM_EN and decim=1, data 0..9, no trigger, stop -> amount=5; reads 0..4 return 0,2,4,6,8.
